// File: rtl/proc_rst_ctrl.sv
// Processor reset/run controller: synchronized reset release, stretched core reset,
// run supervision with per-core error filtering, halt and timeout capture.

module proc_rst_err_filt #(
   parameter int ERR_FILTER = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic err,
   output logic fire
);
   localparam int FW = $clog2(ERR_FILTER + 1);

   logic [FW-1:0] cnt;

   // Counter only lives while running; any non-RUN cycle clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (!en || !err)
         cnt <= '0;
      else if (cnt != FW'(ERR_FILTER))
         cnt <= cnt + FW'(1);
   end

   assign fire = en && err && (cnt == FW'(ERR_FILTER - 1));
endmodule

module proc_rst_ctrl #(
   parameter int NUM_CORES  = 2,
   parameter int RST_CYCLES = 4,
   parameter int ERR_FILTER = 2,
   parameter int CYC_W      = 16,
   parameter int MAX_CYCLES = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_CORES-1:0] err,
   input  logic                 halt_req,
   input  logic                 restart,
   output logic                 core_rst,
   output logic                 run,
   output logic                 done,
   output logic [1:0]           status,
   output logic [NUM_CORES-1:0] err_vec,
   output logic [CYC_W-1:0]     cycle_cnt
);
   localparam int SW = $clog2(RST_CYCLES + 1);

   typedef enum logic [1:0] {S_RESET, S_RUN, S_DONE} state_t;

   state_t               state;
   logic                 sync1, sync2;
   logic [SW-1:0]        stretch;
   logic [NUM_CORES-1:0] fire;
   logic                 in_run;
   logic [CYC_W-1:0]     cnt_nxt;
   logic                 timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= 1'b1;
         sync2 <= sync1;
      end
   end

   assign in_run = (state == S_RUN);

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_filt
      proc_rst_err_filt #(.ERR_FILTER(ERR_FILTER)) u_filt (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (in_run),
         .err   (err[i]),
         .fire  (fire[i])
      );
   end

   // Saturating increment keeps the counter from wrapping when timeout is off.
   assign cnt_nxt = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CYC_W'(1);
   assign timeout = (MAX_CYCLES != 0) && (cnt_nxt == CYC_W'(MAX_CYCLES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_RESET;
         core_rst  <= 1'b1;
         run       <= 1'b0;
         done      <= 1'b0;
         status    <= 2'b00;
         err_vec   <= '0;
         cycle_cnt <= '0;
         stretch   <= '0;
      end else begin
         case (state)
            S_RESET: begin
               if (sync2) begin
                  stretch <= stretch + SW'(1);
                  if ((stretch + SW'(1)) == SW'(RST_CYCLES)) begin
                     state    <= S_RUN;
                     core_rst <= 1'b0;
                     run      <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               cycle_cnt <= cnt_nxt;
               if (|fire) begin
                  state   <= S_DONE;
                  run     <= 1'b0;
                  done    <= 1'b1;
                  status  <= 2'b10;
                  err_vec <= fire;
               end else if (halt_req) begin
                  state  <= S_DONE;
                  run    <= 1'b0;
                  done   <= 1'b1;
                  status <= 2'b01;
               end else if (timeout) begin
                  state  <= S_DONE;
                  run    <= 1'b0;
                  done   <= 1'b1;
                  status <= 2'b11;
               end
            end
            S_DONE: begin
               if (restart) begin
                  state     <= S_RESET;
                  core_rst  <= 1'b1;
                  done      <= 1'b0;
                  status    <= 2'b00;
                  err_vec   <= '0;
                  cycle_cnt <= '0;
                  stretch   <= '0;
               end
            end
            default: begin
               state    <= S_RESET;
               core_rst <= 1'b1;
               run      <= 1'b0;
               done     <= 1'b0;
               stretch  <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_proc_rst_ctrl.sv
// Directed bench for proc_rst_ctrl: reset/restart timing plus a scoreboard of
// expected run results popped when done rises.

module tb_proc_rst_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  err;
   logic        halt_req;
   logic        restart;
   logic        core_rst, run, done;
   logic [1:0]  status;
   logic [1:0]  err_vec;
   logic [15:0] cycle_cnt;

   typedef struct {
      logic [1:0]  status;
      logic [1:0]  err_vec;
      logic [15:0] cyc;
   } exp_t;

   exp_t sb[$];
   int   npass = 0;
   int   ntot  = 0;

   proc_rst_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .err       (err),
      .halt_req  (halt_req),
      .restart   (restart),
      .core_rst  (core_rst),
      .run       (run),
      .done      (done),
      .status    (status),
      .err_vec   (err_vec),
      .cycle_cnt (cycle_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [1:0] st, input logic [1:0] ev, input logic [15:0] cyc);
      exp_t e;
      e.status = st; e.err_vec = ev; e.cyc = cyc;
      sb.push_back(e);
   endtask

   task automatic sb_check(input string tag, input int budget);
      exp_t e;
      int   n = 0;
      while (!done && n < budget) begin
         tick(1);
         n++;
      end
      chk({tag, "_done"}, done, 1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 0, 1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_status"}, status, e.status);
         chk({tag, "_errvec"}, err_vec, e.err_vec);
         chk({tag, "_cyc"}, cycle_cnt, e.cyc);
         chk({tag, "_run"}, run, 0);
      end
   endtask

   // Releases rst_n between edges; core_rst must fall on the 6th rising edge after.
   task automatic do_reset(input string tag);
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 5) chk({tag, "_crst_e5"}, core_rst, 1);
      end
      chk({tag, "_crst_e6"}, core_rst, 0);
      chk({tag, "_run_e6"}, run, 1);
      chk({tag, "_cyc0"}, cycle_cnt, 0);
   endtask

   // Restart from DONE: core_rst held for 4 cycles, then RUN with cleared results.
   task automatic do_restart(input string tag);
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      chk({tag, "_crst"}, core_rst, 1);
      chk({tag, "_done0"}, done, 0);
      chk({tag, "_stat0"}, status, 0);
      chk({tag, "_ev0"}, err_vec, 0);
      chk({tag, "_cyc0"}, cycle_cnt, 0);
      tick(3);
      chk({tag, "_crst_r3"}, core_rst, 1);
      tick(1);
      chk({tag, "_crst_r4"}, core_rst, 0);
      chk({tag, "_run"}, run, 1);
   endtask

   initial begin
      rst_n = 1'b0; err = 2'b00; halt_req = 1'b0; restart = 1'b0;
      tick(2);
      chk("rst_crst", core_rst, 1);
      chk("rst_run", run, 0);
      chk("rst_done", done, 0);
      chk("rst_status", status, 0);
      chk("rst_errvec", err_vec, 0);
      chk("rst_cyc", cycle_cnt, 0);
      do_reset("por");

      // Single-cycle err pulse is filtered; two-cycle err on core 1 fires.
      err = 2'b01; tick(1);
      err = 2'b00; tick(4);
      chk("filt_nodone", done, 0);
      err = 2'b10;
      push(2'b10, 2'b10, 16'd7);
      tick(2);
      err = 2'b00;
      sb_check("err1", 4);
      do_restart("rs1");

      // Error beats halt on the same edge.
      err = 2'b11; tick(1);
      halt_req = 1'b1;
      push(2'b10, 2'b11, 16'd2);
      tick(1);
      err = 2'b00; halt_req = 1'b0;
      sb_check("errhalt", 4);
      do_restart("rs2");

      // Halt at RUN cycle 37; restart ignored while running.
      restart = 1'b1; tick(3); restart = 1'b0;
      chk("rs_ign_run", run, 1);
      chk("rs_ign_crst", core_rst, 0);
      tick(33);
      halt_req = 1'b1;
      push(2'b01, 2'b00, 16'd37);
      tick(1);
      halt_req = 1'b0;
      sb_check("halt37", 4);
      do_restart("rs3");

      // Timeout; inputs ignored and results frozen in DONE.
      push(2'b11, 2'b00, 16'd1000);
      sb_check("tmo", 1100);
      err = 2'b11; halt_req = 1'b1; tick(3);
      err = 2'b00; halt_req = 1'b0;
      chk("done_hold_st", status, 2'b11);
      chk("done_hold_ev", err_vec, 0);
      chk("done_hold_cyc", cycle_cnt, 1000);
      do_restart("rs4");

      // Halt on the timeout edge wins.
      tick(999);
      halt_req = 1'b1;
      push(2'b01, 2'b00, 16'd1000);
      tick(1);
      halt_req = 1'b0;
      sb_check("halt1000", 4);
      do_restart("rs5");

      // Asynchronous reset mid-RUN.
      tick(500);
      chk("mid_cyc", cycle_cnt, 500);
      #2 rst_n = 1'b0;
      #1;
      chk("async_crst", core_rst, 1);
      chk("async_run", run, 0);
      chk("async_cyc", cycle_cnt, 0);
      @(negedge clk);
      do_reset("rerst");

      tick(4);
      halt_req = 1'b1;
      push(2'b01, 2'b00, 16'd5);
      tick(1);
      halt_req = 1'b0;
      sb_check("halt5", 4);
      chk("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
